// File: rtl/parity_stream_gen_chk_pkg.sv
// Shared types for the streaming parity generator/checker.
package parity_pkg;

   typedef enum logic {PAR_EVEN = 1'b0, PAR_ODD = 1'b1} par_mode_t;
   typedef enum logic {ST_IDLE, ST_INFRAME} par_state_t;

endpackage

// File: rtl/parity_stream_gen_chk_if.sv
// Valid/ready beat stream carrying data, a per-beat parity bit and a frame-last marker.
interface parity_stream_gen_chk_if #(
   parameter int DATA_W = 8
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic              par;
   logic              last;

   modport master (output valid, data, par, last, input ready);
   modport slave  (input valid, data, par, last, output ready);
endinterface

// File: rtl/parity_stream_gen_chk_word.sv
// Combinational parity of one word; p_even_o is exposed so the frame accumulator can share it.
module parity_word #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] data_i,
   input  logic              odd_i,
   output logic              p_o,
   output logic              p_even_o
);
   assign p_even_o = ^data_i;
   assign p_o      = p_even_o ^ odd_i;
endmodule

// File: rtl/parity_stream_gen_chk.sv
// Inline parity generator/checker: one registered stage on a valid/ready path with frame parity.
//  state      | meaning
//  ST_IDLE    | next accepted beat opens a frame and latches the parity mode
//  ST_INFRAME | beats are folded into the frame accumulator until s_last
module parity_stream_gen_chk
   import parity_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 odd_sel_i,
   input  logic                 chk_en_i,
   input  logic                 err_clr_i,
   parity_stream_gen_chk_if.slave  s_if,
   parity_stream_gen_chk_if.master m_if,
   output logic                 m_frame_par_o,
   output logic                 m_err_o,
   output logic [CNT_W-1:0]     err_cnt_o
);
   localparam logic S_IDLE    = ST_IDLE;
   localparam logic S_INFRAME = ST_INFRAME;

   logic              state_q, state_d;
   logic              mode_q, mode_d;
   logic              acc_q, acc_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic              m_valid_q, m_par_q, m_last_q, m_fp_q, m_err_q;
   logic [DATA_W-1:0] m_data_q;

   logic s_ready, accept, cur_mode, beat_par, beat_even, frame_even, beat_err;

   assign s_ready  = !m_valid_q || m_if.ready;
   assign accept   = s_if.valid && s_ready;
   // The first beat of a frame uses the live mode select; later beats use the latched one.
   assign cur_mode = (state_q == S_IDLE) ? odd_sel_i : mode_q;

   parity_word #(.DATA_W(DATA_W)) u_beat (
      .data_i   (s_if.data),
      .odd_i    (cur_mode),
      .p_o      (beat_par),
      .p_even_o (beat_even)
   );

   assign frame_even = (state_q == S_IDLE) ? beat_even : (acc_q ^ beat_even);
   assign beat_err   = chk_en_i && (s_if.par != beat_par);

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      acc_d     = acc_q;
      err_cnt_d = err_cnt_q;
      if (accept) begin
         mode_d  = cur_mode;
         acc_d   = frame_even;
         state_d = s_if.last ? S_IDLE : S_INFRAME;
      end
      if (err_clr_i)
         err_cnt_d = '0;
      else if (accept && beat_err && (err_cnt_q != {CNT_W{1'b1}}))
         err_cnt_d = err_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         mode_q    <= 1'b0;
         acc_q     <= 1'b0;
         err_cnt_q <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_par_q   <= 1'b0;
         m_last_q  <= 1'b0;
         m_fp_q    <= 1'b0;
         m_err_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         acc_q     <= acc_d;
         err_cnt_q <= err_cnt_d;
         if (accept) begin
            m_valid_q <= 1'b1;
            m_data_q  <= s_if.data;
            m_par_q   <= beat_par;
            m_last_q  <= s_if.last;
            m_fp_q    <= s_if.last & (frame_even ^ cur_mode);
            m_err_q   <= beat_err;
         end else if (m_if.ready) begin
            m_valid_q <= 1'b0;
         end
      end
   end

   assign s_if.ready    = s_ready;
   assign m_if.valid    = m_valid_q;
   assign m_if.data     = m_data_q;
   assign m_if.par      = m_par_q;
   assign m_if.last     = m_last_q;
   // Frame parity reads as 0 whenever no beat is presented.
   assign m_frame_par_o = m_fp_q & m_valid_q;
   assign m_err_o       = m_err_q;
   assign err_cnt_o     = err_cnt_q;
endmodule

// File: tb/tb_parity_stream_gen_chk.sv
// Bench for parity_stream_gen_chk: directed scenarios plus random traffic against a frame-level model.
module tb_parity_stream_gen_chk;
   logic clk = 1'b0;
   logic rst, odd_sel, chk_en, err_clr, m_frame_par, m_err;
   logic [1:0] err_cnt;
   int n_chk = 0;
   int n_fail = 0;

   parity_stream_gen_chk_if #(.DATA_W(8)) s_if ();
   parity_stream_gen_chk_if #(.DATA_W(8)) m_if ();

   parity_stream_gen_chk #(.DATA_W(8), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .odd_sel_i(odd_sel), .chk_en_i(chk_en), .err_clr_i(err_clr),
      .s_if(s_if), .m_if(m_if), .m_frame_par_o(m_frame_par), .m_err_o(m_err), .err_cnt_o(err_cnt)
   );

   always #5 clk = ~clk;

   // Reference model state: expected outputs plus frame bookkeeping (mode, count of ones so far).
   logic       exp_mv, exp_par, exp_last, exp_err, exp_fpr;
   logic [7:0] exp_data;
   int         exp_cnt, mdl_ones;
   logic       mdl_inframe, mdl_mode, cur_mr;

   function automatic logic exp_fp();
      return exp_mv ? exp_fpr : 1'b0;
   endfunction

   task automatic step(input logic v, input logic [7:0] d, input logic p, input logic l,
                       input logic o, input logic c, input logic clr, input logic mr, input logic r);
      int   ones;
      logic mode, bp, er;
      @(negedge clk);
      rst = r; s_if.valid = v; s_if.data = d; s_if.par = p; s_if.last = l;
      odd_sel = o; chk_en = c; err_clr = clr; m_if.ready = mr; cur_mr = mr;
      @(posedge clk);
      if (r) begin
         exp_mv = 0; exp_par = 0; exp_last = 0; exp_err = 0; exp_fpr = 0; exp_data = 0;
         exp_cnt = 0; mdl_inframe = 0; mdl_ones = 0; mdl_mode = 0;
      end else if (v && (!exp_mv || mr)) begin
         mode = mdl_inframe ? mdl_mode : o;
         ones = (mdl_inframe ? mdl_ones : 0) + $countones(d);
         bp   = (($countones(d) % 2) == 1) ^ mode;
         er   = c && (p != bp);
         exp_mv = 1; exp_data = d; exp_par = bp; exp_last = l; exp_err = er;
         exp_fpr = l ? (((ones % 2) == 1) ^ mode) : 1'b0;
         mdl_mode = mode; mdl_ones = ones; mdl_inframe = !l;
         if (clr) exp_cnt = 0;
         else if (er && exp_cnt < 3) exp_cnt++;
      end else begin
         if (mr) exp_mv = 0;
         if (clr) exp_cnt = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      step(0, 8'h00, 0, 0, 0, 0, 0, 1, 1);
      step(0, 8'h00, 0, 0, 0, 0, 0, 1, 1);
      step(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      n_chk++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_mvalid got=%b exp=0", m_if.valid); end
      n_chk++; if (s_if.ready !== 1'b1) begin n_fail++; $display("FAIL reset_sready got=%b exp=1", s_if.ready); end
      n_chk++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_errcnt got=%0d exp=0", err_cnt); end
      n_chk++; if ({m_frame_par, m_err, m_if.par, m_if.last, m_if.data} !== 12'h0) begin
         n_fail++; $display("FAIL reset_outputs got=%h exp=0", {m_frame_par, m_err, m_if.par, m_if.last, m_if.data}); end
   endtask

   task automatic test_single_even();
      step(1, 8'hA5, 0, 1, 0, 0, 0, 1, 0);
      n_chk++; if (m_if.valid !== 1'b1) begin n_fail++; $display("FAIL single_mvalid got=%b exp=1", m_if.valid); end
      n_chk++; if ({m_if.par, m_frame_par, m_err} !== 3'b000) begin
         n_fail++; $display("FAIL single_par_fp_err got=%b exp=000", {m_if.par, m_frame_par, m_err}); end
      n_chk++; if (m_if.data !== 8'hA5) begin n_fail++; $display("FAIL single_data got=%h exp=a5", m_if.data); end
      step(0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
      n_chk++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL single_drop got=%b exp=0", m_if.valid); end
   endtask

   task automatic test_odd_frame();
      logic [7:0] d [3];
      logic       ep [3];
      d[0] = 8'h01; d[1] = 8'h03; d[2] = 8'h07;
      ep[0] = 0; ep[1] = 1; ep[2] = 0;
      for (int i = 0; i < 3; i++) begin
         step(1, d[i], 0, (i == 2), 1, 0, 0, 1, 0);
         n_chk++; if ({m_if.valid, m_if.par} !== {1'b1, ep[i]}) begin
            n_fail++; $display("FAIL odd_frame_beat%0d valid/par got=%b exp=%b", i, {m_if.valid, m_if.par}, {1'b1, ep[i]}); end
         n_chk++; if (m_frame_par !== (i == 2)) begin
            n_fail++; $display("FAIL odd_frame_fp%0d got=%b exp=%b", i, m_frame_par, (i == 2)); end
      end
      step(0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
   endtask

   task automatic test_backpressure();
      step(1, 8'h11, 0, 1, 0, 0, 0, 0, 0);
      n_chk++; if ({m_if.valid, s_if.ready} !== 2'b10) begin
         n_fail++; $display("FAIL bp_first valid/ready got=%b exp=10", {m_if.valid, s_if.ready}); end
      for (int i = 0; i < 3; i++) begin
         step(1, 8'h22, 0, 1, 0, 0, 0, 0, 0);
         n_chk++; if ({s_if.ready, m_if.data} !== {1'b0, 8'h11}) begin
            n_fail++; $display("FAIL bp_hold%0d ready/data got=%h exp=011", i, {s_if.ready, m_if.data}); end
      end
      step(1, 8'h22, 0, 1, 0, 0, 0, 1, 0);
      n_chk++; if ({m_if.valid, m_if.data} !== {1'b1, 8'h22}) begin
         n_fail++; $display("FAIL bp_release valid/data got=%h exp=122", {m_if.valid, m_if.data}); end
      step(0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
      n_chk++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL bp_nodup got=%b exp=0", m_if.valid); end
   endtask

   task automatic test_check();
      step(0, 8'h00, 0, 0, 0, 0, 1, 1, 0);
      step(1, 8'h0F, 1, 1, 0, 1, 0, 1, 0);
      n_chk++; if ({m_err, err_cnt} !== 3'b101) begin
         n_fail++; $display("FAIL chk_first err/cnt got=%b exp=101", {m_err, err_cnt}); end
      step(1, 8'h0F, 0, 1, 0, 1, 0, 1, 0);
      n_chk++; if ({m_err, err_cnt} !== 3'b001) begin
         n_fail++; $display("FAIL chk_good err/cnt got=%b exp=001", {m_err, err_cnt}); end
      for (int i = 0; i < 5; i++) step(1, 8'h0F, 1, 1, 0, 1, 0, 1, 0);
      n_chk++; if (err_cnt !== 2'd3) begin n_fail++; $display("FAIL chk_saturate got=%0d exp=3", err_cnt); end
      step(1, 8'h0F, 1, 1, 0, 1, 1, 1, 0);
      n_chk++; if ({m_err, err_cnt} !== 3'b100) begin
         n_fail++; $display("FAIL chk_clr_wins err/cnt got=%b exp=100", {m_err, err_cnt}); end
      step(0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
   endtask

   task automatic test_mode_latch();
      step(1, 8'h01, 0, 0, 1, 0, 0, 1, 0);
      n_chk++; if (m_if.par !== 1'b0) begin n_fail++; $display("FAIL mode_b1 par got=%b exp=0", m_if.par); end
      step(1, 8'h02, 0, 0, 0, 0, 0, 1, 0);
      n_chk++; if (m_if.par !== 1'b0) begin n_fail++; $display("FAIL mode_b2 par got=%b exp=0", m_if.par); end
      step(1, 8'h04, 0, 1, 0, 0, 0, 1, 0);
      n_chk++; if ({m_if.par, m_frame_par} !== 2'b00) begin
         n_fail++; $display("FAIL mode_b3 par/fp got=%b exp=00", {m_if.par, m_frame_par}); end
      step(1, 8'h01, 0, 1, 0, 0, 0, 1, 0);
      n_chk++; if ({m_if.par, m_frame_par} !== 2'b11) begin
         n_fail++; $display("FAIL mode_next_even par/fp got=%b exp=11", {m_if.par, m_frame_par}); end
      step(0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
   endtask

   task automatic test_reset_midframe();
      step(1, 8'h01, 0, 0, 1, 0, 0, 1, 0);
      step(1, 8'h00, 0, 0, 1, 0, 0, 1, 0);
      step(0, 8'h00, 0, 0, 0, 0, 0, 1, 1);
      n_chk++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_mvalid got=%b exp=0", m_if.valid); end
      step(1, 8'hFF, 0, 1, 0, 0, 0, 1, 0);
      n_chk++; if ({m_if.valid, m_if.par, m_frame_par} !== 3'b100) begin
         n_fail++; $display("FAIL rstmid_fresh valid/par/fp got=%b exp=100", {m_if.valid, m_if.par, m_frame_par}); end
      step(0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
              1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, 1'b0);
         n_chk++; if ({m_if.valid, s_if.ready, m_frame_par, err_cnt} !== {exp_mv, !exp_mv || cur_mr, exp_fp(), 2'(exp_cnt)}) begin
            n_fail++; $display("FAIL rand%0d valid/ready/fp/cnt got=%b exp=%b", i,
               {m_if.valid, s_if.ready, m_frame_par, err_cnt}, {exp_mv, !exp_mv || cur_mr, exp_fp(), 2'(exp_cnt)}); end
         if (exp_mv) begin
            n_chk++; if ({m_if.data, m_if.par, m_if.last, m_err} !== {exp_data, exp_par, exp_last, exp_err}) begin
               n_fail++; $display("FAIL rand%0d data/par/last/err got=%h exp=%h", i,
                  {m_if.data, m_if.par, m_if.last, m_err}, {exp_data, exp_par, exp_last, exp_err}); end
         end
      end
   endtask

   initial begin
      rst = 1; odd_sel = 0; chk_en = 0; err_clr = 0;
      s_if.valid = 0; s_if.data = 0; s_if.par = 0; s_if.last = 0; m_if.ready = 0;
      test_reset();
      test_single_even();
      test_odd_frame();
      test_backpressure();
      test_check();
      test_mode_latch();
      test_reset_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
